sync_xfer_arbiter: RTL and testbench
====================================

Name: sync_xfer_arbiter

Overview:
Source-domain controller that shares one request/acknowledge clock-domain-crossing channel among NUM_REQ requesters.
- Arbitrates round-robin and presents the winner's data word, held stable, to the crossing.
- Drives a 4-phase handshake: xfer_req goes out through a shift-register synchronizer to the far domain; the far domain's acknowledge returns through another synchronizer as xfer_ack_sync.
- Signals completion to the winning requester.

Parameters:
NUM_REQ, 4, number of requesters (2..8).
DATA_W, 8, width of the data word carried per transfer.
TIMEOUT_CYCLES, 64, cycles to wait for acknowledge before aborting (used only with the optional feature, ≥2).

Ports:
clk  input  1  single clock (source domain).
reset  input  1  synchronous, active-high reset.
req  input  NUM_REQ  per-requester transfer request, level; held until matching done bit.
req_data  input  NUM_REQ*DATA_W  requester i data at bits [i*DATA_W +: DATA_W].
done  output  NUM_REQ  one-cycle completion pulse, one-hot.
xfer_req  output  1  handshake request toward the crossing synchronizer.
xfer_data  output  DATA_W  data word, stable while a transfer is in flight.
xfer_ack_sync  input  1  far-side acknowledge, already synchronized into clk.
busy  output  1  high whenever state is not IDLE.
xfer_err  output  1  one-cycle pulse coincident with done when the transfer timed out.

Behaviour:
- Reset, and reset asserted mid-transfer: state IDLE, done=0, xfer_req=0, xfer_data=0, busy=0, xfer_err=0, rr_ptr=0. An in-flight handshake is abandoned; the far side is expected to be reset too.
- All outputs are registered.
- FSM states IDLE, REQ_HI, REQ_LO.
- IDLE:
  - If req≠0, the winner is the first set bit scanning circularly from rr_ptr upward.
  - Same edge: sel←winner, xfer_data←req_data[winner], xfer_req←1, state←REQ_HI.
  - xfer_req is therefore high in the cycle after req is first sampled.
- REQ_HI: when xfer_ack_sync=1, xfer_req←0 and state←REQ_LO. Otherwise hold.
- REQ_LO: when xfer_ack_sync=0:
  - done[sel]←1 for exactly one cycle.
  - rr_ptr←(sel+1) mod NUM_REQ.
  - state←IDLE.
- Minimum spacing: a new arbitration happens only in an IDLE cycle, so the earliest next xfer_req rise is 2 cycles after a done pulse.
- xfer_data stays constant from the REQ_HI entry edge until the next IDLE grant. Requester changes to req_data mid-transfer are ignored.
- Requester dropping req mid-transfer: ignored. The transfer completes and done still pulses.
- A requester still holding req after its done pulse is a new request, arbitrated fairly.
- xfer_ack_sync in IDLE is ignored.
- Stale ack=1 on REQ_HI entry is accepted as the ack. The synchronizer latency makes this impossible in a correct system.
- Ack stuck high holds the FSM in REQ_LO indefinitely (without the optional feature).
- Single requester, no competition: it is granted back-to-back; pointer rotation does not starve it.
- Without the optional feature, xfer_err is tied 0.

Optional Feature:
Macro SYNC_XFER_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT_CYCLES)-bit counter clears on REQ_HI entry and increments each REQ_HI cycle without ack.
  - When it reaches TIMEOUT_CYCLES-1 with ack still 0: xfer_req←0, a timeout flag is set, state←REQ_LO.
  - On REQ_LO exit, done[sel] and xfer_err pulse together; the flag clears.
  - The REQ_LO wait for ack low is unchanged.
- Undefined: no counter, no flag, xfer_err constant 0, no abort path.

Test Plan:
1. Reset, then req=4'b0010, data1=8'hA5; far model acks 3 cycles after xfer_req rises and drops ack 3 cycles after xfer_req falls -> xfer_req rises cycle+1, xfer_data=8'hA5, done=4'b0010 one cycle after ack falls, busy low next cycle.
2. req=4'b1111 held for 4 transfers from rr_ptr=0 -> grant order 0,1,2,3, then 0 again; each done one-hot; xfer_data matches each requester's word.
3. req=4'b0101 with requester 0 just served -> next grant 2, then 0; requester 2 data=8'h3C held on xfer_data through its whole handshake while req_data[2] changes to 8'hFF.
4. Reset asserted while in REQ_HI -> next cycle xfer_req=0, busy=0, done=0, rr_ptr=0; with req=4'b1000, the next grant is requester 3.
5. Requester 1 drops req while in REQ_LO -> done[1] still pulses; no spurious second grant.
6. With SYNC_XFER_TIMEOUT_EN and TIMEOUT_CYCLES=16, no ack -> xfer_req falls 16 cycles after rising; done[sel] and xfer_err pulse together next cycle. Without the macro, xfer_req stays high for 200 cycles and xfer_err stays 0.

Source files
------------

// File: rtl/sync_xfer_arbiter.sv
// Round-robin arbiter sharing one 4-phase req/ack CDC channel; xfer_req rises the cycle after req is sampled.
// Requesters hold req until their done pulse; the optional ack timeout is enabled by SYNC_XFER_TIMEOUT_EN.
module sync_xfer_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        done,
    output logic                      xfer_req,
    output logic [DATA_W-1:0]         xfer_data,
    input  logic                      xfer_ack_sync,
    output logic                      busy,
    output logic                      xfer_err
);
    localparam int SEL_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("sync_xfer_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 2");
    end

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic                xfer_req_q, xfer_req_d;
    logic [DATA_W-1:0]   xfer_data_q, xfer_data_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;
    logic [SEL_W-1:0]    winner;
    logic                win_found;
    int                  scan_idx;
    logic                timed_out;
    logic                to_flag;

`ifdef SYNC_XFER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             to_q, to_d;

    assign timed_out = !xfer_ack_sync && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign to_flag   = to_q;

    // Counter is held at zero in IDLE, so it starts from zero on every REQ_HI entry.
    always_comb begin
        cnt_d = cnt_q;
        to_d  = to_q;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (state_q == REQ_HI && !xfer_ack_sync && !timed_out) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (state_q == REQ_HI && timed_out) begin
            to_d = 1'b1;
        end else if (state_q == REQ_LO && !xfer_ack_sync) begin
            to_d = 1'b0;
        end
    end
`else
    assign timed_out = 1'b0;
    assign to_flag   = 1'b0;
`endif

    // Circular scan starting at rr_ptr; first set request wins.
    always_comb begin
        winner    = '0;
        win_found = 1'b0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!win_found && req[SEL_W'(scan_idx)]) begin
                win_found = 1'b1;
                winner    = SEL_W'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        rr_ptr_d    = rr_ptr_q;
        xfer_req_d  = xfer_req_q;
        xfer_data_d = xfer_data_q;
        done_d      = '0;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                // The done cycle is skipped so a requester can drop req before it is re-arbitrated.
                if (win_found && (done_q == '0)) begin
                    sel_d       = winner;
                    xfer_data_d = req_data[int'(winner)*DATA_W +: DATA_W];
                    xfer_req_d  = 1'b1;
                    state_d     = REQ_HI;
                end
            end
            REQ_HI: begin
                if (xfer_ack_sync || timed_out) begin
                    xfer_req_d = 1'b0;
                    state_d    = REQ_LO;
                end
            end
            REQ_LO: begin
                if (!xfer_ack_sync) begin
                    done_d[sel_q] = 1'b1;
                    err_d         = to_flag;
                    rr_ptr_d      = (sel_q == SEL_W'(NUM_REQ - 1)) ? '0 : sel_q + 1'b1;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            rr_ptr_q    <= '0;
            xfer_req_q  <= 1'b0;
            xfer_data_q <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef SYNC_XFER_TIMEOUT_EN
            cnt_q       <= '0;
            to_q        <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            rr_ptr_q    <= rr_ptr_d;
            xfer_req_q  <= xfer_req_d;
            xfer_data_q <= xfer_data_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
`ifdef SYNC_XFER_TIMEOUT_EN
            cnt_q       <= cnt_d;
            to_q        <= to_d;
`endif
        end
    end

    assign done      = done_q;
    assign xfer_req  = xfer_req_q;
    assign xfer_data = xfer_data_q;
    assign busy      = busy_q;
    assign xfer_err  = err_q;

endmodule

// File: tb/tb_sync_xfer_arbiter.sv
// Randomized bench for sync_xfer_arbiter: transaction-level round-robin model, grant scoreboard and far-side ack model.
module tb_sync_xfer_arbiter;
    localparam int N  = 4;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  done;
    logic          xfer_req;
    logic [DW-1:0] xfer_data;
    logic          xfer_ack_sync;
    logic          busy;
    logic          xfer_err;

    int checks = 0;
    int errors = 0;

    // far-side configuration, written only by the main process
    logic far_en;
    logic far_rand;
    int   far_dly;

    // reference model state, written only by the monitor
    int            m_exp_q[$];
    int            grant_log[$];
    int            m_rr;
    int            m_hi_len;
    logic          m_prev_xr;
    logic          m_in_lo;
    logic          m_last_done;
    logic          m_exp_err;
    logic          m_started = 1'b0;
    logic [DW-1:0] m_exp_dat;

    int t2_order[5] = '{0, 1, 2, 3, 0};
    int t3_order[2] = '{2, 0};

    sync_xfer_arbiter #(.NUM_REQ(N), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .done(done),
        .xfer_req(xfer_req), .xfer_data(xfer_data), .xfer_ack_sync(xfer_ack_sync),
        .busy(busy), .xfer_err(xfer_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] r, input int start);
        for (int k = 0; k < N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    // Far domain: follows xfer_req with ack after a delay, in both directions.
    initial begin : far_side
        int cnt;
        int dly;
        cnt = 0;
        dly = 3;
        xfer_ack_sync = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (reset === 1'b1) begin
                xfer_ack_sync = 1'b0;
                cnt = 0;
            end else if (far_en && (xfer_req !== xfer_ack_sync)) begin
                if (cnt >= dly) begin
                    xfer_ack_sync = xfer_req;
                    cnt = 0;
                    dly = far_rand ? int'($urandom_range(0, 4)) : far_dly;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
                dly = far_rand ? dly : far_dly;
            end
        end
    end

    // Monitor: inputs only change at negedge+2, so values read here are those the DUT sampled.
    initial begin : monitor
        logic rose, fell, exp_grant, exp_done, lo_prev;
        int w;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                m_started = 1'b1;
                check("rst_done", done, '0);
                check("rst_xfer_req", xfer_req, 1'b0);
                check("rst_busy", busy, 1'b0);
                check("rst_xfer_err", xfer_err, 1'b0);
                check("rst_xfer_data", xfer_data, '0);
                m_exp_q.delete();
                m_rr = 0;
                m_hi_len = 0;
                m_prev_xr = 1'b0;
                m_in_lo = 1'b0;
                m_last_done = 1'b0;
                m_exp_err = 1'b0;
                m_exp_dat = '0;
            end else if (m_started) begin
                rose = xfer_req && !m_prev_xr;
                fell = !xfer_req && m_prev_xr;
                exp_grant = (m_exp_q.size() == 0) && !m_last_done && (req != '0);
                check("grant_rise", rose, exp_grant);
                if (rose) begin
                    w = rr_pick(req, m_rr);
                    if (w < 0) w = 0;
                    m_exp_q.push_back(w);
                    grant_log.push_back(w);
                    m_exp_dat = req_data[w*DW +: DW];
                    m_hi_len = 0;
                end
                check("xfer_data_held", xfer_data, m_exp_dat);
                if (xfer_req) m_hi_len++;
                lo_prev = m_in_lo;
                if (fell) begin
                    m_in_lo = 1'b1;
`ifdef SYNC_XFER_TIMEOUT_EN
                    m_exp_err = !xfer_ack_sync;
                    if (!xfer_ack_sync) check("timeout_len", m_hi_len, TO);
`else
                    m_exp_err = 1'b0;
                    check("fall_on_ack", xfer_ack_sync, 1'b1);
`endif
                end
                exp_done = lo_prev && !xfer_ack_sync;
                check("done_timing", done != '0, exp_done);
                if (done != '0) begin
                    if (m_exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL done_unexpected: got %0h expected no done at %0t", done, $time);
                    end else begin
                        w = m_exp_q.pop_front();
                        check("done_onehot", done, 64'(1) << w);
                        check("xfer_err_done", xfer_err, m_exp_err);
                        m_rr = (w + 1) % N;
                    end
                    m_in_lo = 1'b0;
                end else begin
                    check("xfer_err_idle", xfer_err, 1'b0);
                end
                m_last_done = (done != '0);
                check("busy", busy, m_exp_q.size() != 0);
                m_prev_xr = xfer_req;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_done(input int max, output logic [N-1:0] d);
        d = '0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (done != '0) begin
                d = done;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL wait_done: got no done expected one within %0d cycles", max);
    endtask

    task automatic wait_xreq(input logic lvl, input int max);
        for (int i = 0; i < max; i++) begin
            tick();
            if (xfer_req === lvl) return;
        end
        checks++;
        errors++;
        $display("FAIL wait_xreq: got no xfer_req=%0b expected within %0d cycles", lvl, max);
    endtask

    initial begin : main
        logic [N-1:0] d;
        int base;
        reset = 1'b1;
        req = '0;
        req_data = '0;
        far_en = 1'b1;
        far_rand = 1'b0;
        far_dly = 3;
        repeat (3) tick();
        reset = 1'b0;

        // 1: single request
        req_data[1*DW +: DW] = 8'hA5;
        req = 4'b0010;
        tick();
        check("t1_rise", xfer_req, 1'b1);
        check("t1_data", xfer_data, 8'hA5);
        wait_done(50, d);
        check("t1_done", d, 4'b0010);
        req = '0;
        tick();
        check("t1_busy", busy, 1'b0);

        // 2: all four requesting from rr_ptr=0
        do_reset();
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};
        base = grant_log.size();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_done(60, d);
            check("t2_done", d, 64'(1) << t2_order[k]);
        end
        req = '0;
        check("t2_count", grant_log.size() - base, 5);
        for (int k = 0; k < 5; k++) check("t2_order", grant_log[base + k], t2_order[k]);

        // 3: requester 0 just served; data of 2 changes mid-transfer
        req_data[0*DW +: DW] = 8'h5A;
        req_data[2*DW +: DW] = 8'h3C;
        base = grant_log.size();
        req = 4'b0101;
        wait_xreq(1'b1, 20);
        req_data[2*DW +: DW] = 8'hFF;
        wait_done(60, d);
        check("t3_done2", d, 4'b0100);
        check("t3_data_held", xfer_data, 8'h3C);
        req[2] = 1'b0;
        wait_done(60, d);
        check("t3_done0", d, 4'b0001);
        req[0] = 1'b0;
        for (int k = 0; k < 2; k++) check("t3_order", grant_log[base + k], t3_order[k]);

        // 4: reset during REQ_HI restarts pointer at 0
        far_dly = 10;
        req = 4'b0010;
        wait_done(60, d);
        req = '0;
        req = 4'b1000;
        wait_xreq(1'b1, 20);
        tick();
        reset = 1'b1;
        tick();
        check("t4_xfer_req", xfer_req, 1'b0);
        check("t4_busy", busy, 1'b0);
        check("t4_done", done, '0);
        tick();
        reset = 1'b0;
        far_dly = 3;
        req = 4'b1010;
        wait_done(60, d);
        check("t4_first", d, 4'b0010);
        req[1] = 1'b0;
        wait_done(60, d);
        check("t4_second", d, 4'b1000);
        req = '0;

        // 5: requester drops req while in REQ_LO
        req_data[1*DW +: DW] = 8'h96;
        req = 4'b0010;
        wait_xreq(1'b1, 20);
        wait_xreq(1'b0, 40);
        req[1] = 1'b0;
        wait_done(40, d);
        check("t5_done", d, 4'b0010);
        repeat (6) tick();
        check("t5_no_regrant", xfer_req, 1'b0);
        check("t5_idle", busy, 1'b0);

        // 6: far side never acknowledges
        far_en = 1'b0;
        req_data[2*DW +: DW] = 8'h77;
        req = 4'b0100;
        wait_xreq(1'b1, 20);
`ifdef SYNC_XFER_TIMEOUT_EN
        wait_done(40, d);
        check("t6_done", d, 4'b0100);
        check("t6_err", xfer_err, 1'b1);
        req = '0;
        far_en = 1'b1;
`else
        repeat (200) tick();
        check("t6_stuck_req", xfer_req, 1'b1);
        check("t6_no_err", xfer_err, 1'b0);
        far_en = 1'b1;
        wait_done(40, d);
        check("t6_done", d, 4'b0100);
        req = '0;
`endif

        // 7: lone requester granted back-to-back
        repeat (3) tick();
        base = grant_log.size();
        req = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            wait_done(40, d);
            check("t7_done", d, 4'b0001);
        end
        req = '0;
        for (int k = 0; k < 3; k++) check("t7_order", grant_log[base + k], 0);

        // random traffic
        far_rand = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            tick();
            for (int i = 0; i < N; i++) begin
                if (done[i]) begin
                    if ($urandom_range(0, 1) == 1) req_data[i*DW +: DW] = 8'($urandom);
                    else req[i] = 1'b0;
                end else if (!req[i]) begin
                    if ($urandom_range(0, 3) == 0) begin
                        req[i] = 1'b1;
                        req_data[i*DW +: DW] = 8'($urandom);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_data[i*DW +: DW] = 8'($urandom);
                end
            end
            if (c % 1000 == 999) do_reset();
        end
        req = '0;
        for (int i = 0; i < 100 && (busy || xfer_req); i++) tick();
        check("final_idle", busy, 1'b0);
        repeat (4) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
